// File: rtl/cdb_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cdb_rr_scheduler
// Description : Round-robin common-data-bus arbiter with a one-entry holding
//               buffer per functional-unit requester.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int TW   = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*TW-1:0]   req_tag,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 cdb_write,
    output logic [TW-1:0]        cdb_tag,
    output logic [DW-1:0]        cdb_data,
    output logic [3:0]           pending,
    output logic                 err_tag0
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    r_full;
    logic [TW-1:0]      r_tag  [NREQ];
    logic [DW-1:0]      r_data [NREQ];
    logic [PW-1:0]      r_ptr;
    logic               r_cdb_write;
    logic [TW-1:0]      r_cdb_tag;
    logic [DW-1:0]      r_cdb_data;
    logic [3:0]         r_pending;
    logic               r_err_tag0;

    logic               w_gnt_vld;
    logic [PW-1:0]      w_gnt_idx;
    logic [NREQ-1:0]    w_gnt_onehot;
    logic [PW-1:0]      w_ptr_nxt;
    logic [NREQ-1:0]    w_accept;
    logic [NREQ-1:0]    w_store;
    logic               w_err_set;
    logic [NREQ-1:0]    w_full_nxt;
    logic [3:0]         w_pending_nxt;

    // First full buffer found walking ptr, ptr+1, ... wrapping at NREQ.
    always_comb begin : p_arb
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_gnt_vld && r_full[PW'(idx)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(idx);
            end
        end
    end

    assign w_gnt_onehot = w_gnt_vld ? (NREQ'(1) << w_gnt_idx) : '0;
    assign w_ptr_nxt    = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);

    // Tag-0 results are swallowed: accepted but never stored.
    always_comb begin : p_accept
        w_accept  = req_valid & ~r_full;
        w_store   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_store[i] = w_accept[i] && (req_tag[i*TW +: TW] != '0);
        end
        w_err_set = |(w_accept & ~w_store);
    end

    always_comb begin : p_occupancy
        w_full_nxt    = (r_full & ~w_gnt_onehot) | w_store;
        w_pending_nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pending_nxt = w_pending_nxt + 4'(w_full_nxt[i]);
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_buf
        always_ff @(posedge clock) begin
            if (w_store[gi]) begin
                r_tag[gi]  <= req_tag[gi*TW +: TW];
                r_data[gi] <= req_data[gi*DW +: DW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_full      <= '0;
            r_ptr       <= '0;
            r_cdb_write <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_pending   <= '0;
            r_err_tag0  <= 1'b0;
        end else if (flush) begin
            r_full      <= '0;
            r_cdb_write <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_pending   <= '0;
        end else begin
            r_full      <= w_full_nxt;
            r_pending   <= w_pending_nxt;
            r_cdb_write <= w_gnt_vld;
            if (w_err_set) begin
                r_err_tag0 <= 1'b1;
            end
            if (w_gnt_vld) begin
                r_cdb_tag  <= r_tag[w_gnt_idx];
                r_cdb_data <= r_data[w_gnt_idx];
                r_ptr      <= w_ptr_nxt;
            end else begin
                r_cdb_tag  <= '0;
                r_cdb_data <= '0;
            end
        end
    end

    assign req_ready = ~r_full;
    assign cdb_write = r_cdb_write;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign pending   = r_pending;
    assign err_tag0  = r_err_tag0;

endmodule
`default_nettype wire

// File: tb/tb_cdb_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_rr_scheduler
// Description : Self-checking bench: directed cases plus randomized traffic
//               compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TW = 3;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               flush = 1'b0;
    logic [N-1:0]       req_valid = '0;
    logic [N*TW-1:0]    req_tag = '0;
    logic [N*DW-1:0]    req_data = '0;
    logic [N-1:0]       req_ready;
    logic               cdb_write;
    logic [TW-1:0]      cdb_tag;
    logic [DW-1:0]      cdb_data;
    logic [3:0]         pending;
    logic               err_tag0;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state (state as seen after the most recent edge)
    bit m_full [N];
    int m_tag  [N];
    int m_data [N];
    int m_ptr;
    bit m_cw;
    int m_ct;
    int m_cd;
    bit m_err;

    cdb_rr_scheduler #(.NREQ(N), .DW(DW), .TW(TW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_write (cdb_write),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .pending   (pending),
        .err_tag0  (err_tag0)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] v, input logic [N*TW-1:0] t,
                              input logic [N*DW-1:0] d, input bit fl, input bit rs);
        bit was_full [N];
        int g;
        int i;
        if (rs) begin
            foreach (m_full[j]) m_full[j] = 1'b0;
            m_ptr = 0; m_cw = 0; m_ct = 0; m_cd = 0; m_err = 0;
        end else if (fl) begin
            foreach (m_full[j]) m_full[j] = 1'b0;
            m_cw = 0; m_ct = 0; m_cd = 0;
        end else begin
            foreach (m_full[j]) was_full[j] = m_full[j];
            g = -1;
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (g < 0 && was_full[i]) g = i;
            end
            if (g >= 0) begin
                m_cw = 1; m_ct = m_tag[g]; m_cd = m_data[g];
                m_full[g] = 1'b0;
                m_ptr = (g + 1) % N;
            end else begin
                m_cw = 0; m_ct = 0; m_cd = 0;
            end
            for (int j = 0; j < N; j++) begin
                if (v[j] && !was_full[j]) begin
                    if (t[j*TW +: TW] == 0) begin
                        m_err = 1;
                    end else begin
                        m_full[j] = 1'b1;
                        m_tag[j]  = int'(t[j*TW +: TW]);
                        m_data[j] = int'(d[j*DW +: DW]);
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        int cnt;
        int rdy;
        cnt = 0;
        rdy = 0;
        for (int j = 0; j < N; j++) begin
            if (m_full[j]) cnt++;
            else rdy = rdy | (1 << j);
        end
        cmp("cdb_write", int'(cdb_write), int'(m_cw));
        cmp("cdb_tag",   int'(cdb_tag),   m_ct);
        cmp("cdb_data",  int'(cdb_data),  m_cd);
        cmp("pending",   int'(pending),   cnt);
        cmp("req_ready", int'(req_ready), rdy);
        cmp("err_tag0",  int'(err_tag0),  int'(m_err));
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*TW-1:0] t,
                        input logic [N*DW-1:0] d, input bit fl, input bit rs);
        req_valid = v; req_tag = t; req_data = d; flush = fl; reset = rs;
        model_edge(v, t, d, fl, rs);
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step('0, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        bit            hold [N];
        logic [N-1:0]  rv;
        logic [N*TW-1:0] rt;
        logic [N*DW-1:0] rd;
        bit            rfl, rrs;

        // Reset state
        do_reset();
        cmp("rst_pending", int'(pending), 0);
        cmp("rst_ready",   int'(req_ready), 'hF);
        cmp("rst_write",   int'(cdb_write), 0);

        // Single requester, one-edge latency
        step(4'b0010, 12'h010, 64'h0000_0000_0005_0000, 1'b0, 1'b0);
        cmp("single_pend1", int'(pending), 1);
        cmp("single_nowr",  int'(cdb_write), 0);
        idle();
        cmp("single_wr",    int'(cdb_write), 1);
        cmp("single_tag",   int'(cdb_tag), 2);
        cmp("single_data",  int'(cdb_data), 5);
        cmp("single_pend0", int'(pending), 0);

        // Collision from ptr=0, then ptr must sit at 3
        do_reset();
        step(4'b0101, 12'h0C1, 64'h0000_0009_0000_0007, 1'b0, 1'b0);
        cmp("coll_pend", int'(pending), 2);
        idle();
        cmp("coll_tag1",  int'(cdb_tag), 1);
        cmp("coll_data1", int'(cdb_data), 7);
        idle();
        cmp("coll_tag2",  int'(cdb_tag), 3);
        cmp("coll_data2", int'(cdb_data), 9);
        step(4'b1001, 12'hA04, 64'h0020_0000_0000_0010, 1'b0, 1'b0);
        idle();
        cmp("ptr3_first", int'(cdb_tag), 5);
        idle();
        cmp("ptr3_second", int'(cdb_tag), 4);

        // Fairness: everyone valid, grant order 0,1,2,3,0,...
        do_reset();
        for (int s = 1; s <= 14; s++) begin
            step(4'b1111, 12'h8D1, 64'h0104_0103_0102_0101, 1'b0, 1'b0);
            if (s >= 2) begin
                cmp("rr_write", int'(cdb_write), 1);
                cmp("rr_order", int'(cdb_tag), ((s - 2) % 4) + 1);
            end
        end

        // Backpressure on requester 3
        do_reset();
        step(4'b1111, 12'hAD1, 64'h0011_0000_0000_0000, 1'b0, 1'b0);
        for (int s = 2; s <= 6; s++) begin
            step(4'b1000, 12'hC00, 64'h0022_0000_0000_0000, 1'b0, 1'b0);
            if (s == 2) cmp("bp_ready3", int'(req_ready[3]), 0);
            if (s == 5) begin
                cmp("bp_old_tag",  int'(cdb_tag), 5);
                cmp("bp_old_data", int'(cdb_data), 'h11);
            end
            if (s == 6) cmp("bp_accept", int'(pending), 1);
        end
        idle();
        cmp("bp_new_tag",  int'(cdb_tag), 6);
        cmp("bp_new_data", int'(cdb_data), 'h22);

        // Tag 0 is swallowed and sets the sticky error
        do_reset();
        step(4'b0001, 12'h000, 64'h0000_0000_0000_0033, 1'b0, 1'b0);
        cmp("t0_err",  int'(err_tag0), 1);
        cmp("t0_pend", int'(pending), 0);
        for (int s = 0; s < 3; s++) begin
            idle();
            cmp("t0_nowr",   int'(cdb_write), 0);
            cmp("t0_sticky", int'(err_tag0), 1);
        end
        do_reset();
        cmp("t0_cleared", int'(err_tag0), 0);

        // Flush and reset discard buffered results
        step(4'b0111, 12'h0D1, 64'h0000_0003_0002_0001, 1'b0, 1'b0);
        cmp("fl_pend3", int'(pending), 3);
        step(4'b1000, 12'h800, 64'h0044_0000_0000_0000, 1'b1, 1'b0);
        cmp("fl_pend0", int'(pending), 0);
        cmp("fl_nowr",  int'(cdb_write), 0);
        cmp("fl_ready", int'(req_ready), 'hF);
        for (int s = 0; s < 3; s++) begin
            idle();
            cmp("fl_quiet", int'(cdb_write), 0);
        end
        step(4'b0111, 12'h0D1, 64'h0000_0003_0002_0001, 1'b0, 1'b0);
        step(4'b0000, 12'h000, 64'h0, 1'b1, 1'b1);
        cmp("rs_pend0", int'(pending), 0);
        for (int s = 0; s < 3; s++) begin
            idle();
            cmp("rs_quiet", int'(cdb_write), 0);
        end

        // Randomized traffic; requesters hold an offer until it is taken
        foreach (hold[j]) hold[j] = 1'b0;
        rv = '0; rt = '0; rd = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < N; j++) begin
                if (!hold[j]) begin
                    rv[j] = ($urandom % 3) != 0;
                    rt[j*TW +: TW] = (($urandom % 16) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                    rd[j*DW +: DW] = 16'($urandom);
                end
            end
            rfl = ($urandom % 50) == 0;
            rrs = ($urandom % 300) == 0;
            for (int j = 0; j < N; j++) begin
                hold[j] = rv[j] && !(!m_full[j] && !rfl && !rrs);
            end
            step(rv, rt, rd, rfl, rrs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
